// File: rtl/ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage_if
// Brief    : Bundle of upstream, register-file, write-back and ALU-side
//            signals for the execute operand stage.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_fnc3;
    logic        out_fnc1;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;
    logic [31:0] out_pc;

    modport master (
        output in_valid, in_instr, in_pc, rf_rs1_data, rf_rs2_data,
               wb_en, wb_addr, wb_data, flush, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, out_fnc3, out_fnc1,
               out_op1, out_op2, out_rd, out_we, out_illegal, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, rf_rs1_data, rf_rs2_data,
               wb_en, wb_addr, wb_data, flush, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, out_fnc3, out_fnc1,
               out_op1, out_op2, out_rd, out_we, out_illegal, out_pc
    );
endinterface
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage
// Brief    : RV32I OP/OP-IMM/LUI/AUIPC decode, operand select with write-back
//            forwarding, and one valid/ready pipeline slot feeding the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    ex_operand_stage_if.slave  bus
);
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_F7_ZERO    = 7'b0000000;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rs1_addr;
    logic [4:0]  w_rs2_addr;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic        w_fwd1;
    logic        w_fwd2;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;

    logic        w_legal;
    logic [2:0]  w_fnc3;
    logic        w_fnc1;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic [4:0]  w_rd;
    logic        w_we;
    logic        w_in_ready;
    logic        w_stall;
    logic        w_ref1;
    logic        w_ref2;

    logic        r_valid;
    logic [2:0]  r_fnc3;
    logic        r_fnc1;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [4:0]  r_rd;
    logic        r_we;
    logic        r_illegal;
    logic [31:0] r_pc;
    logic [4:0]  r_rs1_addr;
    logic [4:0]  r_rs2_addr;
    logic        r_rs1_used;
    logic        r_rs2_used;

    assign w_opcode   = bus.in_instr[6:0];
    assign w_f3       = bus.in_instr[14:12];
    assign w_f7       = bus.in_instr[31:25];
    assign w_rs1_addr = bus.in_instr[19:15];
    assign w_rs2_addr = bus.in_instr[24:20];
    assign w_imm_i    = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign w_imm_u    = {bus.in_instr[31:12], 12'b0};

    // x0 always reads zero, even when write-back targets it
    assign w_fwd1    = FWD_EN && bus.wb_en && (bus.wb_addr == w_rs1_addr);
    assign w_fwd2    = FWD_EN && bus.wb_en && (bus.wb_addr == w_rs2_addr);
    assign w_rs1_val = (w_rs1_addr == 5'd0) ? 32'd0 :
                       w_fwd1 ? bus.wb_data : bus.rf_rs1_data;
    assign w_rs2_val = (w_rs2_addr == 5'd0) ? 32'd0 :
                       w_fwd2 ? bus.wb_data : bus.rf_rs2_data;

    always_comb begin
        w_legal    = 1'b0;
        w_fnc3     = 3'd0;
        w_fnc1     = 1'b0;
        w_op1      = 32'd0;
        w_op2      = 32'd0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (w_opcode)
            c_OPC_OP: begin
                w_legal    = (w_f7 == c_F7_ZERO) ||
                             ((w_f7 == c_F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
                w_fnc3     = w_f3;
                w_fnc1     = bus.in_instr[30];
                w_op1      = w_rs1_val;
                w_op2      = w_rs2_val;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            c_OPC_OP_IMM: begin
                if (w_f3 == 3'b001)
                    w_legal = (w_f7 == c_F7_ZERO);
                else if (w_f3 == 3'b101)
                    w_legal = (w_f7 == c_F7_ZERO) || (w_f7 == c_F7_ALT);
                else
                    w_legal = 1'b1;
                w_fnc3     = w_f3;
                w_fnc1     = (w_f3 == 3'b101) ? bus.in_instr[30] : 1'b0;
                w_op1      = w_rs1_val;
                w_op2      = w_imm_i;
                w_rs1_used = 1'b1;
            end
            c_OPC_LUI: begin
                w_legal = 1'b1;
                w_op2   = w_imm_u;
            end
            c_OPC_AUIPC: begin
                w_legal = 1'b1;
                w_op1   = bus.in_pc;
                w_op2   = w_imm_u;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_fnc3     = 3'd0;
            w_fnc1     = 1'b0;
            w_op1      = 32'd0;
            w_op2      = 32'd0;
            w_rs1_used = 1'b0;
            w_rs2_used = 1'b0;
        end
    end

    assign w_rd       = w_legal ? bus.in_instr[11:7] : 5'd0;
    assign w_we       = w_legal && (w_rd != 5'd0);
    assign w_in_ready = !bus.flush && (!r_valid || bus.out_ready);

    // A stalled slot picks up results that commit while it waits
    assign w_stall = r_valid && !bus.out_ready;
    assign w_ref1  = FWD_EN && bus.wb_en && (bus.wb_addr != 5'd0) &&
                     r_rs1_used && (bus.wb_addr == r_rs1_addr);
    assign w_ref2  = FWD_EN && bus.wb_en && (bus.wb_addr != 5'd0) &&
                     r_rs2_used && (bus.wb_addr == r_rs2_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_fnc3     <= 3'd0;
            r_fnc1     <= 1'b0;
            r_op1      <= 32'd0;
            r_op2      <= 32'd0;
            r_rd       <= 5'd0;
            r_we       <= 1'b0;
            r_illegal  <= 1'b0;
            r_pc       <= 32'd0;
            r_rs1_addr <= 5'd0;
            r_rs2_addr <= 5'd0;
            r_rs1_used <= 1'b0;
            r_rs2_used <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (bus.in_valid && w_in_ready) begin
            r_valid    <= 1'b1;
            r_fnc3     <= w_fnc3;
            r_fnc1     <= w_fnc1;
            r_op1      <= w_op1;
            r_op2      <= w_op2;
            r_rd       <= w_rd;
            r_we       <= w_we;
            r_illegal  <= !w_legal;
            r_pc       <= bus.in_pc;
            r_rs1_addr <= w_rs1_addr;
            r_rs2_addr <= w_rs2_addr;
            r_rs1_used <= w_rs1_used;
            r_rs2_used <= w_rs2_used;
        end else begin
            if (r_valid && bus.out_ready)
                r_valid <= 1'b0;
            if (w_stall && w_ref1)
                r_op1 <= bus.wb_data;
            if (w_stall && w_ref2)
                r_op2 <= bus.wb_data;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.rs1_addr    = w_rs1_addr;
    assign bus.rs2_addr    = w_rs2_addr;
    assign bus.out_valid   = r_valid;
    assign bus.out_fnc3    = r_fnc3;
    assign bus.out_fnc1    = r_fnc1;
    assign bus.out_op1     = r_op1;
    assign bus.out_op2     = r_op2;
    assign bus.out_rd      = r_rd;
    assign bus.out_we      = r_we;
    assign bus.out_illegal = r_illegal;
    assign bus.out_pc      = r_pc;
endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_operand_stage
// Brief    : Directed self-checking bench for ex_operand_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ex_operand_stage_if bus ();

    ex_operand_stage #(.FWD_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rf1, input logic [31:0] rf2);
        bus.in_valid    = 1'b1;
        bus.in_instr    = instr;
        bus.in_pc       = pc;
        bus.rf_rs1_data = rf1;
        bus.rf_rs2_data = rf2;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_instr    = 32'd0;
        bus.in_pc       = 32'd0;
        bus.rf_rs1_data = 32'd0;
        bus.rf_rs2_data = 32'd0;
        bus.wb_en       = 1'b0;
        bus.wb_addr     = 5'd0;
        bus.wb_data     = 32'd0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b1;

        #12;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_op1", bus.out_op1, 0);
        chk("rst_rd", bus.out_rd, 0);
        chk("rst_we", bus.out_we, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("rel_in_ready", bus.in_ready, 1);

        // add x3,x1,x2
        drive(32'h002081B3, 32'h100, 32'd5, 32'd7);
        #1;
        chk("add_rs1_addr", bus.rs1_addr, 1);
        chk("add_rs2_addr", bus.rs2_addr, 2);
        step();
        chk("add_valid", bus.out_valid, 1);
        chk("add_fnc3", bus.out_fnc3, 0);
        chk("add_fnc1", bus.out_fnc1, 0);
        chk("add_op1", bus.out_op1, 5);
        chk("add_op2", bus.out_op2, 7);
        chk("add_rd", bus.out_rd, 3);
        chk("add_we", bus.out_we, 1);
        chk("add_ill", bus.out_illegal, 0);
        chk("add_pc", bus.out_pc, 32'h100);

        // srai x5,x6,4
        drive(32'h40435293, 32'h104, 32'h80000000, 32'h55);
        step();
        chk("srai_fnc3", bus.out_fnc3, 3'b101);
        chk("srai_fnc1", bus.out_fnc1, 1);
        chk("srai_op1", bus.out_op1, 32'h80000000);
        chk("srai_op2", bus.out_op2, 32'h404);
        chk("srai_rd", bus.out_rd, 5);

        // addi x1,x0,-1 with write-back to x0
        drive(32'hFFF00093, 32'h108, 32'h1234, 32'h0);
        bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'd9;
        step();
        chk("addi_op1", bus.out_op1, 0);
        chk("addi_op2", bus.out_op2, 32'hFFFFFFFF);
        chk("addi_rd", bus.out_rd, 1);

        // sub x3,x1,x2 with x2 forwarded, then held refresh of x1
        drive(32'h402081B3, 32'h10C, 32'd3, 32'd0);
        bus.wb_addr = 5'd2; bus.wb_data = 32'h11;
        step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.wb_addr = 5'd1; bus.wb_data = 32'h22;
        chk("sub_op1", bus.out_op1, 3);
        chk("sub_op2_fwd", bus.out_op2, 32'h11);
        chk("sub_fnc1", bus.out_fnc1, 1);
        #1;
        chk("sub_stall_in_ready", bus.in_ready, 0);
        step();
        chk("sub_ref_op1", bus.out_op1, 32'h22);
        chk("sub_ref_op2", bus.out_op2, 32'h11);
        chk("sub_ref_valid", bus.out_valid, 1);
        bus.wb_en = 1'b0; bus.out_ready = 1'b1;
        step();
        chk("sub_consumed", bus.out_valid, 0);

        // lui x1,0x12345: unused rs1 field (x8) must not refresh while held
        drive(32'h123450B7, 32'h110, 32'h77, 32'h66);
        step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd8; bus.wb_data = 32'h99;
        step();
        chk("lui_op1", bus.out_op1, 0);
        chk("lui_op2", bus.out_op2, 32'h12345000);
        chk("lui_rd", bus.out_rd, 1);
        bus.wb_en = 1'b0; bus.out_ready = 1'b1;
        step();

        // auipc x3,1
        drive(32'h00001197, 32'h2000, 32'h5, 32'h6);
        step();
        chk("auipc_op1", bus.out_op1, 32'h2000);
        chk("auipc_op2", bus.out_op2, 32'h1000);
        chk("auipc_rd", bus.out_rd, 3);
        chk("auipc_fnc3", bus.out_fnc3, 0);

        // illegal encodings: OP with funct7=0000001, slli with funct7=0100000
        drive(32'h022081B3, 32'h2004, 32'h5, 32'h6);
        step();
        chk("mul_ill", bus.out_illegal, 1);
        chk("mul_we", bus.out_we, 0);
        chk("mul_rd", bus.out_rd, 0);
        chk("mul_op1", bus.out_op1, 0);
        drive(32'h40209093, 32'h2008, 32'h5, 32'h6);
        step();
        chk("slli_ill", bus.out_illegal, 1);

        // unknown opcode, then flush while valid
        drive(32'h0000007F, 32'h200C, 32'h5, 32'h6);
        step();
        chk("opc_ill", bus.out_illegal, 1);
        chk("opc_we", bus.out_we, 0);
        chk("opc_valid", bus.out_valid, 1);
        chk("opc_op2", bus.out_op2, 0);
        drive(32'h002081B3, 32'h2010, 32'h5, 32'h6);
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        step();
        chk("flush_valid", bus.out_valid, 0);
        bus.flush = 1'b0;

        // back-to-back A, B, C with out_ready 1,0,1
        drive(32'h00100513, 32'h3000, 32'h0, 32'h0);
        step();
        chk("b2b_a_rd", bus.out_rd, 10);
        chk("b2b_a_op2", bus.out_op2, 1);
        drive(32'h00200593, 32'h3004, 32'h0, 32'h0);
        #1;
        chk("b2b_b_in_ready", bus.in_ready, 1);
        step();
        chk("b2b_b_rd", bus.out_rd, 11);
        chk("b2b_b_op2", bus.out_op2, 2);
        drive(32'h00300613, 32'h3008, 32'h0, 32'h0);
        bus.out_ready = 1'b0;
        #1;
        chk("b2b_c_blocked", bus.in_ready, 0);
        step();
        chk("b2b_b_held_rd", bus.out_rd, 11);
        chk("b2b_b_held_op2", bus.out_op2, 2);
        chk("b2b_b_held_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        #1;
        chk("b2b_c_in_ready", bus.in_ready, 1);
        step();
        chk("b2b_c_rd", bus.out_rd, 12);
        chk("b2b_c_op2", bus.out_op2, 3);
        chk("b2b_c_pc", bus.out_pc, 32'h3008);

        // reset asserted while stalled
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        step();
        chk("stall_valid", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_rd", bus.out_rd, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_valid", bus.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
